vtiming_gen: RTL and testbench

//  Parametrised successor to vdu: generates VGA timing, character-cell address, glyph row/column
//  and a blinking, shape-selectable text cursor for the VGA text pipeline (vram -> charrom -> vmatrix).

---
 rtl/vtiming_gen.sv | 250 +++++++++++++++++++++++++
 tb/tb_vtiming_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vtiming_gen.sv
`default_nettype none
// ============================================================================
// Module   : vtiming_gen
// Brief    : VGA text-mode timing, cell addressing and blinking cursor.
// Revision : 1.0 - initial release
// ============================================================================
module vtiming_gen #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter bit HS_POL       = 1'b0,
  parameter bit VS_POL       = 1'b0,
  parameter int CHAR_W       = 8,
  parameter int CHAR_H       = 16,
  parameter int ADDR_W       = 13,
  parameter int ROW_W        = 5,
  parameter int PIPE_DLY     = 3,
  parameter int BLINK_FRAMES = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ph0,
  input  logic              cursor_en,
  input  logic              cursor_block,
  input  logic [6:0]        cursor_col,
  input  logic [4:0]        cursor_row,
  output logic              ph1,
  output logic              de,
  output logic              hs,
  output logic              vs,
  output logic [ROW_W-1:0]  row_out,
  output logic [2:0]        col_out,
  output logic [ADDR_W-1:0] video_address,
  output logic              cursor,
  output logic              de_dly,
  output logic              hs_dly,
  output logic              vs_dly,
  output logic              frame_start
);

  localparam int C_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int C_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int C_COLS    = H_ACTIVE / CHAR_W;
  localparam int C_ROWS    = V_ACTIVE / CHAR_H;
  localparam int C_H_W     = $clog2(C_H_TOTAL + 1);
  localparam int C_V_W     = $clog2(C_V_TOTAL + 1);
  localparam int C_CX_W    = (C_COLS > 1) ? $clog2(C_COLS) : 1;
  localparam int C_CY_W    = (C_ROWS > 1) ? $clog2(C_ROWS) : 1;

  localparam logic [C_H_W-1:0]  C_H_LAST     = C_H_W'(C_H_TOTAL - 1);
  localparam logic [C_H_W-1:0]  C_H_ACT      = C_H_W'(H_ACTIVE);
  localparam logic [C_H_W-1:0]  C_H_ACT_LAST = C_H_W'(H_ACTIVE - 1);
  localparam logic [C_H_W-1:0]  C_HS_BEG     = C_H_W'(H_ACTIVE + H_FP);
  localparam logic [C_H_W-1:0]  C_HS_END     = C_H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [C_V_W-1:0]  C_V_LAST     = C_V_W'(C_V_TOTAL - 1);
  localparam logic [C_V_W-1:0]  C_V_ACT      = C_V_W'(V_ACTIVE);
  localparam logic [C_V_W-1:0]  C_V_ACT_LAST = C_V_W'(V_ACTIVE - 1);
  localparam logic [C_V_W-1:0]  C_VS_BEG     = C_V_W'(V_ACTIVE + V_FP);
  localparam logic [C_V_W-1:0]  C_VS_END     = C_V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [2:0]        C_COL_LAST   = 3'(CHAR_W - 1);
  localparam logic [ROW_W-1:0]  C_ROW_LAST   = ROW_W'(CHAR_H - 1);
  localparam logic [ROW_W-1:0]  C_ROW_UL     = ROW_W'(CHAR_H - 2);
  localparam logic [ADDR_W-1:0] C_ADDR_COLS  = ADDR_W'(C_COLS);

  if (H_ACTIVE % CHAR_W != 0) begin : g_chk_hcell
    $error("vtiming_gen: H_ACTIVE must be a multiple of CHAR_W");
  end
  if (V_ACTIVE % CHAR_H != 0) begin : g_chk_vcell
    $error("vtiming_gen: V_ACTIVE must be a multiple of CHAR_H");
  end
  if (CHAR_W > 8 || CHAR_W < 1 || CHAR_H < 2) begin : g_chk_cell
    $error("vtiming_gen: CHAR_W must be 1..8 and CHAR_H at least 2");
  end
  if (PIPE_DLY < 1 || PIPE_DLY > 8) begin : g_chk_dly
    $error("vtiming_gen: PIPE_DLY must be 1..8");
  end

  // Position counters describe the pixel that the next beat will emit.
  logic [C_H_W-1:0]  r_h;
  logic [C_V_W-1:0]  r_v;
  logic [2:0]        r_col;
  logic [C_CX_W-1:0] r_cx;
  logic [ROW_W-1:0]  r_row;
  logic [C_CY_W-1:0] r_cy;
  logic [ADDR_W-1:0] r_line_base;

  logic              r_ph1;
  logic              r_frame_start;
  logic              r_de;
  logic              r_hs_act;
  logic              r_vs_act;
  logic              r_cursor;
  logic [ROW_W-1:0]  r_row_out;
  logic [2:0]        r_col_out;
  logic [ADDR_W-1:0] r_addr;
  logic [PIPE_DLY-1:0][2:0] r_dly;

  logic              w_active;
  logic              w_hs_act;
  logic              w_vs_act;
  logic              w_h_wrap;
  logic              w_v_wrap;
  logic              w_frame_wrap;
  logic              w_cell_hit;
  logic              w_cursor;
  logic              w_blink_ph;
  logic [ADDR_W-1:0] w_addr;

  assign w_active     = (r_h < C_H_ACT) && (r_v < C_V_ACT);
  assign w_hs_act     = (r_h >= C_HS_BEG) && (r_h < C_HS_END);
  assign w_vs_act     = (r_v >= C_VS_BEG) && (r_v < C_VS_END);
  assign w_h_wrap     = (r_h == C_H_LAST);
  assign w_v_wrap     = (r_v == C_V_LAST);
  assign w_frame_wrap = ph0 && w_h_wrap && w_v_wrap;
  assign w_addr       = r_line_base + ADDR_W'(r_cx);
  assign w_cell_hit   = (16'(r_cx) == 16'(cursor_col)) && (16'(r_cy) == 16'(cursor_row));
  assign w_cursor     = w_active && cursor_en && w_blink_ph && w_cell_hit &&
                        (cursor_block || (r_row >= C_ROW_UL));

  // Cell indices only advance inside the active area, so they never run past the screen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h         <= '0;
      r_v         <= '0;
      r_col       <= '0;
      r_cx        <= '0;
      r_row       <= '0;
      r_cy        <= '0;
      r_line_base <= '0;
    end else if (ph0) begin
      if (w_h_wrap) begin
        r_h   <= '0;
        r_col <= '0;
        r_cx  <= '0;
        if (w_v_wrap) begin
          r_v         <= '0;
          r_row       <= '0;
          r_cy        <= '0;
          r_line_base <= '0;
        end else begin
          r_v <= r_v + 1'b1;
          if (r_v < C_V_ACT_LAST) begin
            if (r_row == C_ROW_LAST) begin
              r_row       <= '0;
              r_cy        <= r_cy + 1'b1;
              r_line_base <= r_line_base + C_ADDR_COLS;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end
        end
      end else begin
        r_h <= r_h + 1'b1;
        if (r_h < C_H_ACT_LAST) begin
          if (r_col == C_COL_LAST) begin
            r_col <= '0;
            r_cx  <= r_cx + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ph1         <= 1'b0;
      r_frame_start <= 1'b0;
      r_de          <= 1'b0;
      r_hs_act      <= 1'b0;
      r_vs_act      <= 1'b0;
      r_cursor      <= 1'b0;
      r_row_out     <= '0;
      r_col_out     <= '0;
      r_addr        <= '0;
    end else begin
      r_ph1         <= ph0;
      r_frame_start <= ph0 && (r_h == '0) && (r_v == '0);
      if (ph0) begin
        r_de     <= w_active;
        r_hs_act <= w_hs_act;
        r_vs_act <= w_vs_act;
        r_cursor <= w_cursor;
        if (w_active) begin
          r_addr    <= w_addr;
          r_row_out <= r_row;
          r_col_out <= r_col;
        end
      end
    end
  end

  // Delay taps hold sync *activity*, so a zero reset maps to the inactive level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dly <= '0;
    end else if (ph0) begin
      r_dly[0] <= {r_de, r_hs_act, r_vs_act};
      for (int i = 1; i < PIPE_DLY; i++) begin
        r_dly[i] <= r_dly[i-1];
      end
    end
  end

  if (BLINK_FRAMES == 0) begin : g_blink_off
    assign w_blink_ph = 1'b1;
  end else begin : g_blink_on
    localparam int C_BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [C_BF_W-1:0] C_BF_LAST = C_BF_W'(BLINK_FRAMES - 1);
    logic [C_BF_W-1:0] r_frame_cnt;
    logic              r_blink_ph;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_frame_cnt <= '0;
        r_blink_ph  <= 1'b1;
      end else if (w_frame_wrap) begin
        if (r_frame_cnt == C_BF_LAST) begin
          r_frame_cnt <= '0;
          r_blink_ph  <= ~r_blink_ph;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end

    assign w_blink_ph = r_blink_ph;
  end

  assign ph1           = r_ph1;
  assign frame_start   = r_frame_start;
  assign de            = r_de;
  assign hs            = HS_POL ? r_hs_act : ~r_hs_act;
  assign vs            = VS_POL ? r_vs_act : ~r_vs_act;
  assign cursor        = r_cursor;
  assign row_out       = r_row_out;
  assign col_out       = r_col_out;
  assign video_address = r_addr;
  assign de_dly        = r_dly[PIPE_DLY-1][2];
  assign hs_dly        = HS_POL ? r_dly[PIPE_DLY-1][1] : ~r_dly[PIPE_DLY-1][1];
  assign vs_dly        = VS_POL ? r_dly[PIPE_DLY-1][0] : ~r_dly[PIPE_DLY-1][0];

endmodule
`default_nettype wire

// File: tb/tb_vtiming_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vtiming_gen
// Brief    : Directed self-checking bench for vtiming_gen on a small raster.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vtiming_gen;

  // 40x36 raster, 8x4 cells -> 4x8 character grid, 1440 beats per frame.
  localparam int H_TOTAL = 40;
  localparam int V_TOTAL = 36;
  localparam int FRAME   = H_TOTAL * V_TOTAL;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ph0 = 1'b0;
  logic        cursor_en, cursor_block;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;

  logic        ph1, de, hs, vs, cursor, de_dly, hs_dly, vs_dly, frame_start;
  logic [4:0]  row_out;
  logic [2:0]  col_out;
  logic [12:0] video_address;

  logic        p_ph1, p_de, p_hs, p_vs, p_cursor, p_de_dly, p_hs_dly, p_vs_dly, p_frame_start;
  logic [4:0]  p_row_out;
  logic [2:0]  p_col_out;
  logic [12:0] p_video_address;

  vtiming_gen #(
    .H_ACTIVE(32), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(32), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CHAR_W(8), .CHAR_H(4),
    .ADDR_W(13), .ROW_W(5), .PIPE_DLY(3), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ph0(ph0), .cursor_en(cursor_en),
    .cursor_block(cursor_block), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .ph1(ph1), .de(de), .hs(hs), .vs(vs), .row_out(row_out), .col_out(col_out),
    .video_address(video_address), .cursor(cursor), .de_dly(de_dly),
    .hs_dly(hs_dly), .vs_dly(vs_dly), .frame_start(frame_start)
  );

  vtiming_gen #(
    .H_ACTIVE(32), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(32), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CHAR_W(8), .CHAR_H(4),
    .ADDR_W(13), .ROW_W(5), .PIPE_DLY(3), .BLINK_FRAMES(2)
  ) dut_p (
    .clk(clk), .rst_n(rst_n), .ph0(ph0), .cursor_en(cursor_en),
    .cursor_block(cursor_block), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .ph1(p_ph1), .de(p_de), .hs(p_hs), .vs(p_vs), .row_out(p_row_out), .col_out(p_col_out),
    .video_address(p_video_address), .cursor(p_cursor), .de_dly(p_de_dly),
    .hs_dly(p_hs_dly), .vs_dly(p_vs_dly), .frame_start(p_frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit exp_de(input int n);
    if (n < 0) return 1'b0;
    return ((n % H_TOTAL) < 32) && (((n / H_TOTAL) % V_TOTAL) < 32);
  endfunction

  function automatic bit exp_hs_act(input int n);
    if (n < 0) return 1'b0;
    return ((n % H_TOTAL) >= 34) && ((n % H_TOTAL) < 38);
  endfunction

  function automatic bit exp_vs_act(input int n);
    if (n < 0) return 1'b0;
    return (((n / H_TOTAL) % V_TOTAL) >= 33) && (((n / H_TOTAL) % V_TOTAL) < 35);
  endfunction

  int n_beat  = 0;
  bit epoch   = 1'b0;
  bit ph_en   = 1'b0;
  int clk_div = 0;
  int de_cnt[8], hs_lo[8], vs_lo[8], cur_cnt[8];
  int mm_de = 0, mm_hs = 0, mm_vs = 0, mm_dly = 0, mm_pol = 0, mm_fs = 0, mm_ph1 = 0, mm_cur = 0;
  int fs_cnt = 0;

  task automatic check_beat(input int n);
    int h, v, f;
    h = n % H_TOTAL;
    v = (n / H_TOTAL) % V_TOTAL;
    f = n / FRAME;
    if (de !== exp_de(n)) mm_de++;
    if (hs !== !exp_hs_act(n)) mm_hs++;
    if (vs !== !exp_vs_act(n)) mm_vs++;
    if (de_dly !== exp_de(n-3) || hs_dly !== !exp_hs_act(n-3) || vs_dly !== !exp_vs_act(n-3)) mm_dly++;
    if (p_hs !== exp_hs_act(n) || p_vs !== exp_vs_act(n) || p_hs_dly !== exp_hs_act(n-3)) mm_pol++;
    if (frame_start !== (h == 0 && v == 0)) mm_fs++;
    if (ph1 !== 1'b1) mm_ph1++;
    if (n == 0) begin
      chk(epoch ? "fs_after_reset" : "fs_first", frame_start, 1);
      chk(epoch ? "addr_after_reset" : "addr_first", video_address, 0);
    end
    if (!epoch) begin
      if (frame_start) fs_cnt++;
      if (f < 8) begin
        if (de)     de_cnt[f]++;
        if (!hs)    hs_lo[f]++;
        if (!vs)    vs_lo[f]++;
        if (cursor) cur_cnt[f]++;
      end
      if (cursor && !(h >= 8 && h <= 15 && v >= 8 && v <= 11)) mm_cur++;
      case (n)
        168: begin
          chk("addr_8_4", video_address, 5); chk("row_8_4", row_out, 0); chk("col_8_4", col_out, 0);
        end
        253: begin
          chk("addr_13_6", video_address, 5); chk("row_13_6", row_out, 2); chk("col_13_6", col_out, 5);
        end
        435: begin
          chk("addr_hblank_hold", video_address, 11); chk("col_hblank_hold", col_out, 7);
        end
        1271: begin
          chk("addr_last", video_address, 31); chk("row_last", row_out, 3); chk("col_last", col_out, 7);
        end
        1325: begin
          chk("addr_vblank_hold", video_address, 31); chk("row_vblank_hold", row_out, 3);
        end
        1440: begin
          chk("addr_frame1", video_address, 0); chk("fs_frame1", frame_start, 1);
        end
        default: ;
      endcase
    end
  endtask

  // ph0 is one clk in four; a beat is a posedge that saw ph0 high.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && ph0) begin
        check_beat(n_beat);
        n_beat++;
      end
      ph0 = ph_en && (clk_div == 3);
      clk_div = (clk_div + 1) % 4;
    end
  end

  task automatic chk_reset(input string sfx);
    chk({"rst_de", sfx}, de, 0);
    chk({"rst_hs", sfx}, hs, 1);
    chk({"rst_vs", sfx}, vs, 1);
    chk({"rst_addr", sfx}, video_address, 0);
    chk({"rst_rowcol", sfx}, {row_out, col_out}, 0);
    chk({"rst_cursor_fs_ph1", sfx}, {cursor, frame_start, ph1}, 0);
    chk({"rst_dly", sfx}, {de_dly, hs_dly, vs_dly}, 3'b011);
    chk({"rst_pol_sync", sfx}, {p_hs, p_vs, p_hs_dly, p_vs_dly}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      de_cnt[i] = 0; hs_lo[i] = 0; vs_lo[i] = 0; cur_cnt[i] = 0;
    end
    cursor_en = 1'b1; cursor_block = 1'b0; cursor_col = 7'd1; cursor_row = 5'd2;
    rst_n = 1'b0; ph_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("_init");
    rst_n = 1'b1; ph_en = 1'b1;

    // Cursor changes land in vertical blanking so whole frames see one setting.
    wait (n_beat >= 1400); cursor_row = 5'd9;
    wait (n_beat >= 2840); cursor_row = 5'd2;
    wait (n_beat >= 7160); cursor_block = 1'b1;

    // Freeze right after emitting pixel (13,6) of frame 6.
    wait (n_beat >= 6 * FRAME + 254);
    ph_en = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("frz_addr", video_address, 5);
    chk("frz_rowcol", {row_out, col_out}, {5'd2, 3'd5});
    chk("frz_de_hs_vs", {de, hs, vs}, 3'b111);
    chk("frz_strobes", {ph1, frame_start, cursor}, 0);
    chk("frz_dly", {de_dly, hs_dly, vs_dly}, 3'b111);
    ph_en = 1'b1;

    // Reset mid-frame after pixel (20,20) of frame 6.
    wait (n_beat >= 6 * FRAME + 821);
    ph_en = 1'b0;
    rst_n = 1'b0;
    n_beat = 0;
    epoch = 1'b1;
    #1;
    chk_reset("_mid");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; ph_en = 1'b1;
    wait (n_beat >= 60);
    @(negedge clk);

    chk("de_beats_f0", de_cnt[0], 1024);
    chk("de_beats_f1", de_cnt[1], 1024);
    chk("hs_low_f0", hs_lo[0], 144);
    chk("vs_low_f0", vs_lo[0], 80);
    chk("cursor_f0_underline", cur_cnt[0], 16);
    chk("cursor_f1_offscreen", cur_cnt[1], 0);
    chk("cursor_f2_blink_off", cur_cnt[2], 0);
    chk("cursor_f3_blink_off", cur_cnt[3], 0);
    chk("cursor_f4_underline", cur_cnt[4], 16);
    chk("cursor_f5_block", cur_cnt[5], 32);
    chk("frame_start_count", fs_cnt, 7);
    chk("de_beat_errs", mm_de, 0);
    chk("hs_beat_errs", mm_hs, 0);
    chk("vs_beat_errs", mm_vs, 0);
    chk("dly_beat_errs", mm_dly, 0);
    chk("pol_beat_errs", mm_pol, 0);
    chk("fs_beat_errs", mm_fs, 0);
    chk("ph1_beat_errs", mm_ph1, 0);
    chk("cursor_window_errs", mm_cur, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
